// File: rtl/vram_fetch_arbiter_if.sv
// rtl/vram_fetch_arbiter_if.sv - host request/ack bus into the VRAM fetch arbiter
interface vram_fetch_arbiter_if;
   logic        req;
   logic        we;
   logic [11:0] adr;
   logic [7:0]  wd;
   logic        ack;
   logic [7:0]  rd;
   logic        rd_vld;

   modport master (output req, we, adr, wd, input  ack, rd, rd_vld);
   modport slave  (input  req, we, adr, wd, output ack, rd, rd_vld);
endinterface

// File: rtl/vram_fetch_arbiter.sv
// rtl/vram_fetch_arbiter.sv - text VRAM port scheduler: display prefetch, screen clear, host access
module vram_fetch_arbiter #(
   parameter int         C_H_PX_N   = 780,
   parameter int         C_V_LINE_N = 263,
   parameter int         C_COLS     = 80,
   parameter int         C_ROWS     = 30,
   parameter int         C_FETCH_PH = 0,
   parameter logic [7:0] C_CLR_CODE = 8'h20
) (
   input  logic                 i_ck,
   input  logic                 i_rst,
   input  logic                 i_ck_ee,
   input  logic [9:0]           i_hctr,
   input  logic [8:0]           i_vctr,
   input  logic                 i_clr,
   output logic                 o_clr_busy,
   output logic [11:0]          o_ram_adr,
   output logic [7:0]           o_ram_wd,
   output logic                 o_ram_we,
   output logic                 o_ram_re,
   input  logic [7:0]           i_ram_rd,
   output logic [7:0]           o_char_code,
   output logic                 o_char_vld,
   vram_fetch_arbiter_if.slave  io_host
);

   localparam logic [9:0]  C_LS_H      = 10'(C_H_PX_N - 8 + C_FETCH_PH);
   localparam logic [8:0]  C_V_LAST    = 9'(C_V_LINE_N - 1);
   localparam logic [8:0]  C_ACT_LINES = 9'(C_ROWS * 8);
   localparam logic [7:0]  C_COLS_L    = 8'(C_COLS);
   localparam logic [2:0]  C_PH        = 3'(C_FETCH_PH);
   localparam logic [11:0] C_CELLS     = 12'(C_COLS * C_ROWS);

   typedef enum logic [1:0] {H_IDLE, H_GNT, H_HOLD} host_st_t;

   host_st_t    r_host_st, w_host_st_nxt;

   logic [7:0]  w_mid_col;
   logic [8:0]  w_next_line;
   logic        w_mid_ok, w_ls_ok, w_slot;
   logic [8:0]  w_line;
   logic [7:0]  w_col;
   logic [4:0]  w_row;
   logic [11:0] w_fetch_adr;
   logic        w_clr_start, w_clr_wr, w_host_gnt;

   logic [11:0] r_ram_adr;
   logic [7:0]  r_ram_wd;
   logic        r_ram_we, r_ram_re;
   logic        r_re_fetch, r_rd_fetch, r_re_host, r_rd_host;
   logic [7:0]  r_char_code, r_host_rd;
   logic        r_char_vld, r_host_rd_vld;
   logic        r_clr_busy;
   logic [11:0] r_clr_adr;

   // Fetch slot decode: next cell on this line, or column 0 of the next line near end of line
   always_comb begin
      w_mid_col   = {1'b0, i_hctr[9:3]} + 8'd1;
      w_next_line = (i_vctr == C_V_LAST) ? 9'd0 : i_vctr + 9'd1;
      w_mid_ok    = (i_hctr[2:0] == C_PH) && (w_mid_col < C_COLS_L) && (i_vctr < C_ACT_LINES);
      w_ls_ok     = (i_hctr == C_LS_H) && (w_next_line < C_ACT_LINES);
      w_slot      = w_mid_ok || w_ls_ok;
      w_line      = w_ls_ok ? w_next_line : i_vctr;
      w_col       = w_ls_ok ? 8'd0 : w_mid_col;
      w_row       = 5'(w_line >> 3);
      // row*80 as row*64 + row*16 keeps this a pair of shifts and adds
      w_fetch_adr = {1'b0, w_row, 6'd0} + {3'd0, w_row, 4'd0} + {4'd0, w_col};
   end

   // Port arbitration (fetch > clear > host) and host FSM next state
   always_comb begin
      w_host_st_nxt = r_host_st;
      w_clr_wr      = 1'b0;
      w_host_gnt    = 1'b0;
      w_clr_start   = i_clr && !r_clr_busy;
      if (!w_slot) begin
         if (r_clr_busy) begin
            w_clr_wr = (r_clr_adr != C_CELLS);
         end else if (r_host_st == H_IDLE && io_host.req && !w_clr_start) begin
            w_host_gnt = 1'b1;
         end
      end
      case (r_host_st)
         H_IDLE:  if (w_host_gnt) w_host_st_nxt = H_GNT;
         H_GNT:   w_host_st_nxt = H_HOLD;
         default: w_host_st_nxt = H_IDLE;
      endcase
   end

   // Host FSM state register
   always_ff @(posedge i_ck) begin
      if (i_rst) begin
         r_host_st <= H_IDLE;
      end else if (i_ck_ee) begin
         r_host_st <= w_host_st_nxt;
      end
   end

   // Registered VRAM command for the winner of this cycle
   always_ff @(posedge i_ck) begin
      if (i_rst) begin
         r_ram_re   <= 1'b0;
         r_ram_we   <= 1'b0;
         r_ram_adr  <= '0;
         r_ram_wd   <= '0;
         r_re_fetch <= 1'b0;
         r_re_host  <= 1'b0;
      end else if (i_ck_ee) begin
         r_ram_re   <= w_slot || (w_host_gnt && !io_host.we);
         r_ram_we   <= w_clr_wr || (w_host_gnt && io_host.we);
         r_re_fetch <= w_slot;
         r_re_host  <= w_host_gnt && !io_host.we;
         if (w_slot)          r_ram_adr <= w_fetch_adr;
         else if (w_clr_wr)   r_ram_adr <= r_clr_adr;
         else if (w_host_gnt) r_ram_adr <= io_host.adr;
         else                 r_ram_adr <= '0;
         if (w_clr_wr)                       r_ram_wd <= C_CLR_CODE;
         else if (w_host_gnt && io_host.we)  r_ram_wd <= io_host.wd;
         else                                r_ram_wd <= '0;
      end
   end

   // Read return: RAM data arrives the cycle after the strobe and is steered by its tag
   always_ff @(posedge i_ck) begin
      if (i_rst) begin
         r_rd_fetch    <= 1'b0;
         r_rd_host     <= 1'b0;
         r_char_vld    <= 1'b0;
         r_char_code   <= '0;
         r_host_rd_vld <= 1'b0;
         r_host_rd     <= '0;
      end else if (i_ck_ee) begin
         r_rd_fetch    <= r_re_fetch;
         r_rd_host     <= r_re_host;
         r_char_vld    <= r_rd_fetch;
         r_host_rd_vld <= r_rd_host;
         if (r_rd_fetch) r_char_code <= i_ram_rd;
         if (r_rd_host)  r_host_rd   <= i_ram_rd;
      end
   end

   // Clear sequencer: busy stays up one cycle past the last write issue so the final strobe is covered
   always_ff @(posedge i_ck) begin
      if (i_rst) begin
         r_clr_busy <= 1'b0;
         r_clr_adr  <= '0;
      end else if (i_ck_ee) begin
         if (w_clr_start) begin
            r_clr_busy <= 1'b1;
            r_clr_adr  <= '0;
         end else if (r_clr_busy && r_clr_adr == C_CELLS) begin
            r_clr_busy <= 1'b0;
            r_clr_adr  <= '0;
         end else if (w_clr_wr) begin
            r_clr_adr  <= r_clr_adr + 12'd1;
         end
      end
   end

   assign o_ram_re       = r_ram_re;
   assign o_ram_we       = r_ram_we;
   assign o_ram_adr      = r_ram_adr;
   assign o_ram_wd       = r_ram_wd;
   assign o_char_code    = r_char_code;
   assign o_char_vld     = r_char_vld;
   assign o_clr_busy     = r_clr_busy;
   assign io_host.ack    = (r_host_st == H_GNT);
   assign io_host.rd     = r_host_rd;
   assign io_host.rd_vld = r_host_rd_vld;

endmodule
